sdr_cmd_monitor: RTL and testbench

- Parametrised passive monitor on the SDRAM command bus and controller read path of the sdrc_core environment; successor to the fixed-width whitebox probe set.
- Decodes every SDRAM command and tracks per-bank open/closed state.
- Checks refresh interval against cfg_sdr_rfsh and read-data latency against cfg_sdr_cas, and keeps saturating command statistics.
- Instantiated in the bench and bound to controller/SDRAM pins; never drives the DUT.

---
 rtl/sdr_mon_pkg.sv | 23 ++
 rtl/sdr_rd_lat_chk.sv | 41 ++++
 rtl/sdr_cmd_monitor.sv | 148 ++++++++++++++
 tb/tb_sdr_cmd_monitor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_mon_pkg.sv
// Shared command encodings and decode helper for the SDRAM command monitor.
package sdr_mon_pkg;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  // Deselected or clock-disabled cycles are NOPs regardless of ras/cas/we.
  function automatic cmd_e sdr_decode(input logic cke, input logic cs_n,
                                      input logic ras_n, input logic cas_n,
                                      input logic we_n);
    if (!cke || cs_n) return CMD_NOP;
    return cmd_e'({ras_n, cas_n, we_n});
  endfunction

endpackage

// File: rtl/sdr_rd_lat_chk.sv
// Read-data latency checker: expected rd_valid beats travel down a shift register.
module sdr_rd_lat_chk
  import sdr_mon_pkg::*;
#(
  parameter int RD_PIPE   = 2,
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init_done,
  input  logic       rd_cmd,
  input  logic [2:0] cas,
  input  logic       rd_valid,
  output logic       lat_mis
);

  localparam int D = 7 + RD_PIPE + BURST_LEN;
  localparam logic [D-1:0] BEATS = D'((1 << BURST_LEN) - 1);

  logic [D-1:0] exp_sr;
  logic [D-1:0] sched;
  int unsigned  lat;
  int unsigned  sh;

  // exp_sr[0] is the expectation for the current cycle; a new read lands
  // one slot early because the register shifts on the same edge.
  always_comb begin
    lat   = 32'(cas) + RD_PIPE;
    sh    = (lat == 0) ? 0 : lat - 1;
    sched = BEATS << sh;
  end

  assign lat_mis = init_done && (rd_valid != exp_sr[0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       exp_sr <= '0;
    else if (!init_done) exp_sr <= '0;
    else                exp_sr <= (exp_sr >> 1) | (rd_cmd ? sched : '0);
  end

endmodule

// File: rtl/sdr_cmd_monitor.sv
// Passive SDRAM command-bus monitor: bank tracking, refresh/latency checks, stats.
module sdr_cmd_monitor
  import sdr_mon_pkg::*;
#(
  parameter int AW         = 13,
  parameter int BW         = 2,
  parameter int RFSH_W     = 12,
  parameter int CNT_W      = 16,
  parameter int RD_PIPE    = 2,
  parameter int BURST_LEN  = 4,
  parameter int RFSH_SLACK = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cke,
  input  logic                cs_n,
  input  logic                ras_n,
  input  logic                cas_n,
  input  logic                we_n,
  input  logic [AW-1:0]       addr,
  input  logic [BW-1:0]       ba,
  input  logic                init_done,
  input  logic [RFSH_W-1:0]   cfg_sdr_rfsh,
  input  logic [2:0]          cfg_sdr_cas,
  input  logic                rd_valid,
  input  logic                clr_stats,
  output logic                cmd_valid,
  output logic [2:0]          cmd_code,
  output logic [2**BW-1:0]    bank_open,
  output logic                err_act_open,
  output logic                err_rw_closed,
  output logic                err_rfsh_open,
  output logic                err_rfsh_late,
  output logic                err_rd_lat,
  output logic                err_sticky,
  output logic [CNT_W-1:0]    cnt_act,
  output logic [CNT_W-1:0]    cnt_rd,
  output logic [CNT_W-1:0]    cnt_wr,
  output logic [CNT_W-1:0]    cnt_ref,
  output logic [RFSH_W-1:0]   max_rfsh_gap
);

  localparam int NB = 2**BW;

  cmd_e              cmd;
  logic [NB-1:0]     bank_nxt;
  logic              bank_hit, is_rw, is_ref;
  logic              e_act, e_rw, e_ref, e_late, e_lat;
  logic [RFSH_W-1:0] gap;
  logic              late_done;
  logic [RFSH_W:0]   late_thr;
  logic              unused_addr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
    return (hit && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  assign cmd         = sdr_decode(cke, cs_n, ras_n, cas_n, we_n);
  assign bank_hit    = bank_open[ba];
  assign is_rw       = (cmd == CMD_RD) || (cmd == CMD_WR);
  assign is_ref      = (cmd == CMD_REF);
  assign unused_addr = ^(addr & ~(AW'(1) << 10));

  always_comb begin
    bank_nxt = bank_open;
    case (cmd)
      CMD_ACT:        bank_nxt[ba] = 1'b1;
      CMD_PRE:        if (addr[10]) bank_nxt = '0; else bank_nxt[ba] = 1'b0;
      CMD_RD, CMD_WR: if (addr[10]) bank_nxt[ba] = 1'b0;
      default: ;
    endcase
  end

  // Threshold is one bit wider so cfg + slack cannot wrap onto a small gap.
  assign late_thr = {1'b0, cfg_sdr_rfsh} + (RFSH_W+1)'(RFSH_SLACK);
  assign e_act    = init_done && (cmd == CMD_ACT) && bank_hit;
  assign e_rw     = init_done && is_rw && !bank_hit;
  assign e_ref    = init_done && is_ref && (|bank_open);
  assign e_late   = init_done && !late_done && ({1'b0, gap} == late_thr);

  sdr_rd_lat_chk #(.RD_PIPE(RD_PIPE), .BURST_LEN(BURST_LEN)) u_rd_lat (
    .clk       (clk),
    .reset_n   (reset_n),
    .init_done (init_done),
    .rd_cmd    (cmd == CMD_RD),
    .cas       (cfg_sdr_cas),
    .rd_valid  (rd_valid),
    .lat_mis   (e_lat)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid     <= 1'b0;
      cmd_code      <= 3'b000;
      bank_open     <= '0;
      err_act_open  <= 1'b0;
      err_rw_closed <= 1'b0;
      err_rfsh_open <= 1'b0;
      err_rfsh_late <= 1'b0;
      err_rd_lat    <= 1'b0;
      err_sticky    <= 1'b0;
      cnt_act       <= '0;
      cnt_rd        <= '0;
      cnt_wr        <= '0;
      cnt_ref       <= '0;
      max_rfsh_gap  <= '0;
      gap           <= '0;
      late_done     <= 1'b0;
    end else begin
      cmd_valid     <= (cmd != CMD_NOP);
      cmd_code      <= (cmd != CMD_NOP) ? cmd : 3'b000;
      bank_open     <= bank_nxt;
      err_act_open  <= e_act;
      err_rw_closed <= e_rw;
      err_rfsh_open <= e_ref;
      err_rfsh_late <= e_late;
      err_rd_lat    <= e_lat;

      // late_done limits err_rfsh_late to one pulse per refresh interval
      if (!init_done) begin
        gap       <= '0;
        late_done <= 1'b0;
      end else begin
        if (is_ref)         gap <= RFSH_W'(1);
        else if (gap != '1) gap <= gap + RFSH_W'(1);
        if (is_ref)      late_done <= 1'b0;
        else if (e_late) late_done <= 1'b1;
      end

      if (clr_stats) begin
        cnt_act      <= '0;
        cnt_rd       <= '0;
        cnt_wr       <= '0;
        cnt_ref      <= '0;
        max_rfsh_gap <= '0;
        err_sticky   <= 1'b0;
      end else begin
        err_sticky <= err_sticky | e_act | e_rw | e_ref | e_late | e_lat;
        cnt_act    <= sat_inc(cnt_act, cmd == CMD_ACT);
        cnt_rd     <= sat_inc(cnt_rd,  cmd == CMD_RD);
        cnt_wr     <= sat_inc(cnt_wr,  cmd == CMD_WR);
        cnt_ref    <= sat_inc(cnt_ref, is_ref);
        if (init_done && is_ref && gap > max_rfsh_gap) max_rfsh_gap <= gap;
      end
    end
  end

endmodule

// File: tb/tb_sdr_cmd_monitor.sv
// Randomised + directed bench for sdr_cmd_monitor with a cycle-indexed reference model.
module tb_sdr_cmd_monitor;

  localparam int AW = 13, BW = 2, NB = 4, RFSH_W = 12, CNT_W = 4;
  localparam int RD_PIPE = 2, BURST_LEN = 4, RFSH_SLACK = 8;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam int GMAX = (1 << RFSH_W) - 1;
  localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR = 3'b100, C_RD = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

  logic clk = 1'b0;
  logic reset_n, cke, cs_n, ras_n, cas_n, we_n;
  logic [AW-1:0] addr;
  logic [BW-1:0] ba;
  logic init_done, rd_valid, clr_stats;
  logic [RFSH_W-1:0] cfg_sdr_rfsh;
  logic [2:0] cfg_sdr_cas;
  logic cmd_valid;
  logic [2:0] cmd_code;
  logic [NB-1:0] bank_open;
  logic err_act_open, err_rw_closed, err_rfsh_open, err_rfsh_late, err_rd_lat, err_sticky;
  logic [CNT_W-1:0] cnt_act, cnt_rd, cnt_wr, cnt_ref;
  logic [RFSH_W-1:0] max_rfsh_gap;

  always #5 clk = ~clk;

  sdr_cmd_monitor #(.AW(AW), .BW(BW), .RFSH_W(RFSH_W), .CNT_W(CNT_W), .RD_PIPE(RD_PIPE),
                    .BURST_LEN(BURST_LEN), .RFSH_SLACK(RFSH_SLACK)) dut (
    .clk(clk), .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .addr(addr), .ba(ba), .init_done(init_done), .cfg_sdr_rfsh(cfg_sdr_rfsh),
    .cfg_sdr_cas(cfg_sdr_cas), .rd_valid(rd_valid), .clr_stats(clr_stats),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .bank_open(bank_open),
    .err_act_open(err_act_open), .err_rw_closed(err_rw_closed), .err_rfsh_open(err_rfsh_open),
    .err_rfsh_late(err_rfsh_late), .err_rd_lat(err_rd_lat), .err_sticky(err_sticky),
    .cnt_act(cnt_act), .cnt_rd(cnt_rd), .cnt_wr(cnt_wr), .cnt_ref(cnt_ref),
    .max_rfsh_gap(max_rfsh_gap));

  // err bits: [4] act_open [3] rw_closed [2] rfsh_open [1] rfsh_late [0] rd_lat
  typedef struct {
    bit v; bit [2:0] code; bit [NB-1:0] bo; bit [4:0] err; bit sticky;
    int cact, crd, cwr, cref, mgap;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int errors = 0, checks = 0;

  // reference model state (absolute cycle numbers, not a counter copy)
  int k = 0, anchor = 0;
  bit run = 0, late_seen = 0;
  bit pend[int];
  bit [NB-1:0] m_bank = '0;
  bit m_sticky = 0;
  int m_cact = 0, m_crd = 0, m_cwr = 0, m_cref = 0, m_max = 0;
  int rd_skew = 0;
  bit rd_flip = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("cmd_valid", cmd_valid, me.v);
      if (me.v) chk("cmd_code", cmd_code, me.code);
      chk("bank_open", bank_open, me.bo);
      chk("err_act_open", err_act_open, me.err[4]);
      chk("err_rw_closed", err_rw_closed, me.err[3]);
      chk("err_rfsh_open", err_rfsh_open, me.err[2]);
      chk("err_rfsh_late", err_rfsh_late, me.err[1]);
      chk("err_rd_lat", err_rd_lat, me.err[0]);
      chk("err_sticky", err_sticky, me.sticky);
      chk("cnt_act", cnt_act, me.cact);
      chk("cnt_rd", cnt_rd, me.crd);
      chk("cnt_wr", cnt_wr, me.cwr);
      chk("cnt_ref", cnt_ref, me.cref);
      chk("max_rfsh_gap", max_rfsh_gap, me.mgap);
    end
  end

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  // Drive rd_valid, predict the outputs after the coming edge, then advance.
  task automatic tick();
    exp_t e;
    bit v, hit;
    bit [2:0] code;
    bit [4:0] er;
    int gb, thr;
    if (!reset_n) rd_valid = 1'b0;
    else          rd_valid = (init_done && pend.exists(k + rd_skew)) ^ rd_flip;
    code = {ras_n, cas_n, we_n};
    v = cke && !cs_n && code != C_NOP;
    e = '{default: 0};
    if (!reset_n) begin
      m_bank = '0; run = 0; late_seen = 0; pend.delete(); m_sticky = 0;
      m_cact = 0; m_crd = 0; m_cwr = 0; m_cref = 0; m_max = 0;
    end else begin
      hit = m_bank[ba];
      gb = run ? ((k - anchor > GMAX) ? GMAX : k - anchor) : 0;
      thr = int'(cfg_sdr_rfsh) + RFSH_SLACK;
      er[4] = init_done && v && code == C_ACT && hit;
      er[3] = init_done && v && (code == C_RD || code == C_WR) && !hit;
      er[2] = init_done && v && code == C_REF && m_bank != 0;
      er[1] = init_done && !late_seen && gb == thr;
      er[0] = init_done && (rd_valid != pend.exists(k));
      if (v) begin
        if (code == C_ACT) m_bank[ba] = 1'b1;
        if (code == C_PRE) begin
          if (addr[10]) m_bank = '0; else m_bank[ba] = 1'b0;
        end
        if ((code == C_RD || code == C_WR) && addr[10]) m_bank[ba] = 1'b0;
      end
      if (!init_done) begin
        run = 0; late_seen = 0; pend.delete();
      end else begin
        if ((v && code == C_REF) || !run) begin run = 1; anchor = k; late_seen = 0; end
        else if (er[1]) late_seen = 1;
        if (v && code == C_RD)
          for (int b = 0; b < BURST_LEN; b++) pend[k + int'(cfg_sdr_cas) + RD_PIPE + b] = 1'b1;
        if (pend.exists(k)) pend.delete(k);
      end
      if (clr_stats) begin
        m_sticky = 0; m_cact = 0; m_crd = 0; m_cwr = 0; m_cref = 0; m_max = 0;
      end else begin
        m_sticky = m_sticky | (|er);
        if (v && code == C_ACT) m_cact = sat(m_cact);
        if (v && code == C_RD)  m_crd  = sat(m_crd);
        if (v && code == C_WR)  m_cwr  = sat(m_cwr);
        if (v && code == C_REF) m_cref = sat(m_cref);
        if (init_done && v && code == C_REF && gb > m_max) m_max = gb;
      end
      e.v = v; e.code = v ? code : 3'b000; e.bo = m_bank; e.err = er; e.sticky = m_sticky;
      e.cact = m_cact; e.crd = m_crd; e.cwr = m_cwr; e.cref = m_cref; e.mgap = m_max;
    end
    sb.push_back(e);
    k++;
    @(negedge clk);
    #1;
  endtask

  task automatic set_nop();
    cke = 1'b1; cs_n = 1'b0; {ras_n, cas_n, we_n} = C_NOP;
  endtask

  task automatic issue(input logic [2:0] c, input int b, input bit a10);
    cke = 1'b1; cs_n = 1'b0; {ras_n, cas_n, we_n} = c;
    ba = BW'(b);
    addr = AW'($urandom);
    addr[10] = a10;
    tick();
    set_nop();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_pulse();
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rc;
    int r;
    reset_n = 1'b0; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP;
    addr = '0; ba = '0; init_done = 1'b0; cfg_sdr_rfsh = 12'd100; cfg_sdr_cas = 3'd3;
    rd_valid = 1'b0; clr_stats = 1'b0;
    @(negedge clk);
    #1;
    idle(3);                       // reset state
    reset_n = 1'b1;
    set_nop();
    idle(3);                       // before init_done: tracking only
    init_done = 1'b1;
    idle(2);

    issue(C_ACT, 1, 0); idle(1);   // clean read, CAS 3
    issue(C_RD, 1, 0);  idle(10);
    rd_skew = 1;                   // data one cycle early
    issue(C_RD, 1, 0);  idle(10);
    rd_skew = 0;
    issue(C_RD, 2, 0);  idle(3);   // read to closed bank
    clr_pulse();        idle(8);

    issue(C_PRE, 0, 1);            // refresh interval 120 vs 100+8
    issue(C_REF, 0, 0); idle(119);
    issue(C_REF, 0, 0); idle(3);

    issue(C_ACT, 0, 0); issue(C_ACT, 3, 0); issue(C_PRE, 0, 1);
    issue(C_REF, 0, 0); idle(2);
    issue(C_ACT, 0, 0); issue(C_ACT, 3, 0);
    issue(C_REF, 0, 0); idle(2);

    issue(C_ACT, 2, 0);            // counter saturation
    for (int i = 0; i < 20; i++) issue(C_WR, 2, 0);
    idle(1); clr_pulse(); idle(2);
    issue(C_ACT, 2, 0);            // ACT to open bank
    issue(C_RD, 2, 1);  idle(1);   // auto-precharge closes it
    issue(C_WR, 2, 0);  idle(8);

    cfg_sdr_cas = 3'd2;            // CAS change and init_done drop mid-read
    issue(C_ACT, 1, 0); issue(C_RD, 1, 0); idle(2);
    cfg_sdr_cas = 3'd3;
    issue(C_RD, 1, 0); idle(1);
    init_done = 1'b0; idle(3);
    init_done = 1'b1; idle(8);

    issue(C_RD, 1, 0); idle(5);    // reset mid-burst
    reset_n = 1'b0; idle(2);
    reset_n = 1'b1; idle(10);

    cfg_sdr_rfsh = 12'd20;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 20) rc = C_ACT;
      else if (r < 35) rc = C_RD;
      else if (r < 50) rc = C_WR;
      else if (r < 58) rc = C_PRE;
      else if (r < 62) rc = C_REF;
      else if (r < 64) rc = C_MRS;
      else if (r < 66) rc = C_BST;
      else             rc = C_NOP;
      cke = ($urandom_range(0, 19) != 0);
      cs_n = ($urandom_range(0, 9) == 0);
      {ras_n, cas_n, we_n} = rc;
      ba = BW'($urandom);
      addr = AW'($urandom);
      addr[10] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) cfg_sdr_cas = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd2;
      clr_stats = ($urandom_range(0, 63) == 0);
      rd_flip = ($urandom_range(0, 31) == 0);
      init_done = ($urandom_range(0, 149) != 0);
      reset_n = (i != 700);
      tick();
    end
    clr_stats = 1'b0; rd_flip = 1'b0; init_done = 1'b1; reset_n = 1'b1;
    set_nop();
    idle(12);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
